tube_display8: RTL
==================

// Module: tube_display8
// PURPOSE
//   CPU-writable output peripheral on the system bridge: drives an 8-digit, common-anode,
//   multiplexed 7-segment tube from a 32-bit hex value (one nibble per digit).
//   Output counterpart to the DIP-switch input device: CPU writes, board displays.
//   Data and control registers are read back through dout for software read-modify-write.
// PARAMETERS
//   SCAN_DIV   50000  clk cycles per digit slot; legal range >= 2
//   CNT_W      16     width of the prescaler counter; must satisfy 2**CNT_W >= SCAN_DIV
// PORTS
//   clk        in   1   system clock; all state updates on posedge
//   reset      in   1   synchronous, active-high reset
//   we         in   1   bridge write strobe for this device
//   addr       in   3   word address: 3'b000 = DATA, 3'b001 = CTRL, others unmapped
//   be         in   4   byte enables for writes; be[i] covers din[8i+7:8i]
//   din        in   32  write data
//   dout       out  32  read data (combinational)
//   digit_sel  out  8   digit anodes, active low; bit k = digit k (k=0 is rightmost)
//   seg        out  8   segments {dp,g,f,e,d,c,b,a}, active low
// BEHAVIOUR
//   Registers
//   - DATA[31:0]: digit k shows DATA[4k+3:4k] in hex (0-9, A-F).
//   - CTRL[0] = enable; CTRL[15:8] = digit mask (1 = digit lit); CTRL[23:16] = dp per digit.
//   - Other CTRL bits: write-ignored, read as 0.
//   Reset values
//   - DATA = 0; CTRL = 32'h0000_FF01; prescaler = 0; digit index = 0.
//   - digit_sel = 8'hFF; seg = 8'hFF.
//   Writes
//   - When we=1 and addr is 0 or 1, each byte with be[i]=1 updates at the clk edge.
//   - Writes to unmapped addresses are ignored; with we=0, nothing changes.
//   - reset=1 overrides a write in the same cycle.
//   Read
//   - dout = DATA when addr=0, CTRL (masked to implemented bits) when addr=1, else 0.
//   - Reads have no side effects.
//   Scan
//   - Prescaler counts 0 to SCAN_DIV-1, then wraps to 0.
//   - On the wrap edge, the digit index advances 0 to 7, then wraps to 0.
//   - Every digit is therefore lit for exactly SCAN_DIV cycles per 8*SCAN_DIV frame.
//   Output stage (registered, 1 cycle after index/register state)
//   - Current digit idx is lit when enable=1 and mask[idx]=1.
//   - If lit: digit_sel = ~(8'b1<<idx); seg = {~dp[idx], ~hexdecode(nibble)}.
//   - Otherwise: digit_sel = 8'hFF and seg = 8'hFF (blanked slot; scan timing is unchanged).
//   Latency
//   - A write at edge N changes the currently scanned digit's outputs at edge N+1.
//   - Non-scanned digits pick up the change when next scanned.
//   - Writes never reset or stall the prescaler or the index.
//   Reset mid-frame
//   - Next edge returns all state to reset values; the scan restarts at digit 0.
// CONFIGURATION
//   Macro TUBE_DISPLAY_BLINK_EN
//   - Defined:
//     - CTRL[24] = blink enable, reset 0.
//     - An 8-bit frame counter increments on each digit-7-to-0 wrap.
//     - While CTRL[24]=1 and frame_cnt[7]=1, all slots are blanked.
//     - CTRL[24] reads back.
//   - Undefined:
//     - No frame counter is built.
//     - CTRL[24] is write-ignored and reads 0.
//     - No blanking beyond enable/mask.
// TESTING (SCAN_DIV=4)
//   1. Reset 3 cycles, then release.
//      -> digit_sel=FF, seg=FF during reset; dout(addr0)=0, dout(addr1)=0000_FF01.
//   2. Write DATA=32'h1234_ABCD, be=F.
//      -> digit 0 shows 'D' (digit_sel=FE, seg=8'hA1).
//      -> digit 7 shows '1' (digit_sel=7F, seg=8'hF9).
//      -> each digit is lit for 4 cycles; frame is 32 cycles.
//   3. Write DATA with be=4'b0010, din=32'hxxxx_EE00.
//      -> readback 1234_EECD; only digits 2 and 3 change to 'E'.
//   4. Write CTRL=32'h0001_0F01.
//      -> digits 4-7 blanked (FF/FF) in their slots; digit 0 dp lit (seg[7]=0).
//   5. Assert reset on the 2nd cycle of digit 5, together with we=1 to DATA.
//      -> the write is dropped; after release, the scan restarts at digit 0 with DATA=0.
//   6. With TUBE_DISPLAY_BLINK_EN defined, set CTRL[24]=1.
//      -> outputs stay blanked for frames 128-255 of each 256-frame period.
//      Without the macro: CTRL[24] reads 0 and no blanking occurs.

Source files
------------

// File: rtl/tube_display8.sv
// tube_display8: CPU-writable 8-digit common-anode multiplexed 7-segment driver.
// DATA holds eight hex nibbles (digit k <- DATA[4k+3:4k]); CTRL holds enable,
// per-digit mask and per-digit decimal point. A prescaler walks the digit index
// so each digit owns one SCAN_DIV-cycle slot of an 8*SCAN_DIV-cycle frame.
// Optional feature macro: TUBE_DISPLAY_BLINK_EN adds CTRL[24] blink enable and
// an 8-bit frame counter; while blinking, frames 128-255 of every 256 are blank.
module tube_display8 #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [3:0]  be,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [7:0]  digit_sel,
    output logic [7:0]  seg
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       ADDR_DATA  = 3'b000;
    localparam logic [2:0]       ADDR_CTRL  = 3'b001;

    // Architectural registers
    logic [31:0]      data_q, data_d;
    logic             en_q, en_d;
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       dp_q, dp_d;

    // Scan state
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;

    // Registered tube drive
    logic [7:0]       digit_sel_q, digit_sel_d;
    logic [7:0]       seg_q, seg_d;

    logic             wr_data;
    logic             wr_ctrl;
    logic             presc_wrap;
    logic             blank_all;
    logic             slot_lit;
    logic [3:0]       nibble;
    logic [31:0]      ctrl_rd;

`ifdef TUBE_DISPLAY_BLINK_EN
    logic             blink_q, blink_d;
    logic [7:0]       frame_q, frame_d;
`endif

    // Hex digit to active-high {g,f,e,d,c,b,a} pattern
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'h0: f = 7'h3F;
            4'h1: f = 7'h06;
            4'h2: f = 7'h5B;
            4'h3: f = 7'h4F;
            4'h4: f = 7'h66;
            4'h5: f = 7'h6D;
            4'h6: f = 7'h7D;
            4'h7: f = 7'h07;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h6F;
            4'hA: f = 7'h77;
            4'hB: f = 7'h7C;
            4'hC: f = 7'h39;
            4'hD: f = 7'h5E;
            4'hE: f = 7'h79;
            default: f = 7'h71;
        endcase
        return f;
    endfunction

    assign wr_data = we && (addr == ADDR_DATA);
    assign wr_ctrl = we && (addr == ADDR_CTRL);

    // Byte-enabled register writes; unimplemented CTRL bits are simply not stored
    always_comb begin
        data_d = data_q;
        en_d   = en_q;
        mask_d = mask_q;
        dp_d   = dp_q;
`ifdef TUBE_DISPLAY_BLINK_EN
        blink_d = blink_q;
`endif
        if (wr_data) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) data_d[8*i +: 8] = din[8*i +: 8];
            end
        end
        if (wr_ctrl) begin
            if (be[0]) en_d   = din[0];
            if (be[1]) mask_d = din[15:8];
            if (be[2]) dp_d   = din[23:16];
`ifdef TUBE_DISPLAY_BLINK_EN
            if (be[3]) blink_d = din[24];
`endif
        end
    end

    // Prescaler and digit index; register writes never disturb the scan
    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d      = presc_wrap ? idx_q + 3'd1 : idx_q;
    end

`ifdef TUBE_DISPLAY_BLINK_EN
    // Frame counter ticks when the scan leaves digit 7; its MSB gates blinking
    always_comb begin
        frame_d   = (presc_wrap && (idx_q == 3'd7)) ? frame_q + 8'd1 : frame_q;
        blank_all = blink_q && frame_q[7];
    end
`else
    assign blank_all = 1'b0;
`endif

    // Output stage input: decode the currently scanned digit from live register state
    always_comb begin
        nibble      = data_q[{idx_q, 2'b00} +: 4];
        slot_lit    = en_q && mask_q[idx_q] && !blank_all;
        digit_sel_d = 8'hFF;
        seg_d       = 8'hFF;
        if (slot_lit) begin
            digit_sel_d = ~(8'b1 << idx_q);
            seg_d       = {~dp_q[idx_q], ~hex_font(nibble)};
        end
    end

    // Readback view of CTRL with unimplemented bits forced to zero
    always_comb begin
        ctrl_rd        = '0;
        ctrl_rd[0]     = en_q;
        ctrl_rd[15:8]  = mask_q;
        ctrl_rd[23:16] = dp_q;
`ifdef TUBE_DISPLAY_BLINK_EN
        ctrl_rd[24]    = blink_q;
`endif
    end

    // Combinational read mux; reads have no side effects
    always_comb begin
        dout = '0;
        if (addr == ADDR_DATA)      dout = data_q;
        else if (addr == ADDR_CTRL) dout = ctrl_rd;
    end

    // All state; synchronous reset wins over any write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q      <= '0;
            en_q        <= 1'b1;
            mask_q      <= 8'hFF;
            dp_q        <= 8'h00;
            presc_q     <= '0;
            idx_q       <= 3'd0;
            digit_sel_q <= 8'hFF;
            seg_q       <= 8'hFF;
`ifdef TUBE_DISPLAY_BLINK_EN
            blink_q     <= 1'b0;
            frame_q     <= 8'd0;
`endif
        end else begin
            data_q      <= data_d;
            en_q        <= en_d;
            mask_q      <= mask_d;
            dp_q        <= dp_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
`ifdef TUBE_DISPLAY_BLINK_EN
            blink_q     <= blink_d;
            frame_q     <= frame_d;
`endif
        end
    end

    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule
